// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the 640x480 raster (794 x 528 total) and the
// 8x8-pixel cell map, plus small helpers used by the VRAM arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] H_TOTAL    = 10'd794;
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] V_TOTAL    = 10'd528;
  localparam int         CELL_SHIFT = 3;
  localparam logic [9:0] PREFETCH_H = 10'd788;
  localparam logic [9:0] LINE_END_H = 10'd793;

  // Column-fetch slots sit at phase 2 of each 8-pixel column; the last one
  // (hcount 626) fetches column 79. Transfers sit at phase 7; the last one
  // (hcount 631) hands over column 79.
  localparam logic [2:0] FETCH_PHASE       = 3'd2;
  localparam logic [2:0] XFER_PHASE        = 3'd7;
  localparam logic [9:0] COL_FETCH_LAST_H  = 10'd626;
  localparam logic [9:0] COL_XFER_LAST_H   = 10'd631;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_COL,
    SLOT_NEXT_LINE
  } slot_e;

  // Line that follows v, wrapping at the end of the frame.
  function automatic logic [9:0] next_line(input logic [9:0] v);
    return (v == V_TOTAL - 10'd1) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/cell_addr_calc.sv
// -----------------------------------------------------------------------------
// cell_addr_calc
// Combinational cell address: row*80 + col, built as (row<<6)+(row<<4)+col.
// Ports:
//   i_row  [5:0]        cell row    (0..59)
//   i_col  [6:0]        cell column (0..79)
//   o_addr [ADDR_W-1:0] linear cell address
// -----------------------------------------------------------------------------
module cell_addr_calc #(
  parameter int ADDR_W = 13
) (
  input  logic [5:0]        i_row,
  input  logic [6:0]        i_col,
  output logic [ADDR_W-1:0] o_addr
);

  assign o_addr = (ADDR_W'(i_row) << 6) + (ADDR_W'(i_row) << 4) + ADDR_W'(i_col);

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares a single-port cell-map memory between the raster display fetch and
// a one-deep game-logic request port. Phase 2 of each active 8-pixel column
// (and hcount 788 for the next line's column 0) is reserved for display;
// every other cycle is granted to game logic. Also emits a frame tick at the
// start of vertical blank.
// Ports:
//   clock, resetn             pixel clock, async active-low reset
//   hcount, vcount            raster position from the sync generator
//   gl_valid/gl_we/gl_addr/gl_wdata   game-logic request
//   gl_ready                  grant (combinational, independent of gl_valid)
//   gl_rvalid/gl_rdata        read response, two cycles after the handshake
//   mem_addr/mem_we/mem_wdata registered memory command
//   mem_rdata                 memory read data, one cycle after mem_addr
//   cell_data                 cell for the current 8-pixel column
//   frame_tick                one-cycle pulse at vertical-blank start
// -----------------------------------------------------------------------------
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              gl_valid,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_ready,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] cell_data,
  output logic              frame_tick
);

  if (COLS * ROWS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("vram_arbiter: ADDR_W too small for COLS*ROWS");
  end

  // ---------------------------------------------------------------------------
  // Slot decoder
  // ---------------------------------------------------------------------------
  logic [9:0]        w_next_v;
  logic              w_col_slot;
  logic              w_nl_slot;
  slot_e             w_slot;
  logic [5:0]        w_row;
  logic [6:0]        w_col;
  logic [ADDR_W-1:0] w_slot_addr;
  logic              w_accept;
  logic              w_xfer;

  assign w_next_v   = next_line(vcount);
  assign w_col_slot = (vcount < V_ACTIVE) &&
                      (hcount[CELL_SHIFT-1:0] == FETCH_PHASE) &&
                      (hcount <= COL_FETCH_LAST_H);
  assign w_nl_slot  = (hcount == PREFETCH_H) && (w_next_v < V_ACTIVE);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_slot = SLOT_NONE;
    if (w_col_slot)     w_slot = SLOT_COL;
    else if (w_nl_slot) w_slot = SLOT_NEXT_LINE;
  end

  // One address calculator serves both fetch kinds. A column fetch reads the
  // column after the one currently being drawn.
  always_comb begin
    w_row = vcount[CELL_SHIFT+5:CELL_SHIFT];
    w_col = hcount[9:CELL_SHIFT] + 7'd1;
    if (w_slot == SLOT_NEXT_LINE) begin
      w_row = w_next_v[CELL_SHIFT+5:CELL_SHIFT];
      w_col = 7'd0;
    end
  end

  cell_addr_calc #(.ADDR_W(ADDR_W)) u_cell_addr_calc (
    .i_row  (w_row),
    .i_col  (w_col),
    .o_addr (w_slot_addr)
  );

  assign gl_ready = (w_slot == SLOT_NONE);
  assign w_accept = gl_valid && gl_ready;
  assign w_xfer   = ((hcount[CELL_SHIFT-1:0] == XFER_PHASE) && (hcount <= COL_XFER_LAST_H)) ||
                    (hcount == LINE_END_H);

  // ---------------------------------------------------------------------------
  // Command, response and capture registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_disp_tag;   // command on mem_* is a display fetch
  logic              r_disp_rdy;   // mem_rdata holds display data
  logic              r_rd_tag;     // command on mem_* is a game read
  logic              r_rvalid;     // mem_rdata holds game read data
  logic [DATA_W-1:0] r_next_cell;
  logic [DATA_W-1:0] r_cell_data;
  logic              r_frame_tick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_disp_tag   <= 1'b0;
      r_disp_rdy   <= 1'b0;
      r_rd_tag     <= 1'b0;
      r_rvalid     <= 1'b0;
      r_next_cell  <= '0;
      r_cell_data  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      // Idle cycles keep the last address but never write.
      r_mem_we   <= 1'b0;
      r_disp_tag <= 1'b0;
      r_rd_tag   <= 1'b0;
      if (w_slot != SLOT_NONE) begin
        r_mem_addr <= w_slot_addr;
        r_disp_tag <= 1'b1;
      end else if (w_accept) begin
        r_mem_addr  <= gl_addr;
        r_mem_we    <= gl_we;
        r_mem_wdata <= gl_wdata;
        r_rd_tag    <= !gl_we;
      end

      r_disp_rdy <= r_disp_tag;
      r_rvalid   <= r_rd_tag;

      if (r_disp_rdy) r_next_cell <= mem_rdata;
      if (w_xfer)     r_cell_data <= r_next_cell;

      r_frame_tick <= (hcount == LINE_END_H) && (vcount == V_ACTIVE - 10'd1);
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign gl_rvalid  = r_rvalid;
  // Read data comes straight from memory in the response cycle; it is gated
  // so the port reads zero whenever no response is being presented.
  assign gl_rdata   = r_rvalid ? mem_rdata : '0;
  assign cell_data  = r_cell_data;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Self-checking bench for vram_arbiter with a write-first synchronous memory
// model preloaded with addr mod 16. Raster position is driven directly so the
// bench can jump to the interesting points of a frame.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [9:0]  hcount, vcount;
  logic        gl_valid, gl_we;
  logic [12:0] gl_addr;
  logic [3:0]  gl_wdata;
  logic        gl_ready, gl_rvalid;
  logic [3:0]  gl_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic [3:0]  cell_data;
  logic        frame_tick;

  always #5 clock = ~clock;

  vram_arbiter #(.DATA_W(4), .COLS(80), .ROWS(60), .ADDR_W(13)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .hcount     (hcount),
    .vcount     (vcount),
    .gl_valid   (gl_valid),
    .gl_we      (gl_we),
    .gl_addr    (gl_addr),
    .gl_wdata   (gl_wdata),
    .gl_ready   (gl_ready),
    .gl_rvalid  (gl_rvalid),
    .gl_rdata   (gl_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cell_data  (cell_data),
    .frame_tick (frame_tick)
  );

  // Write-first synchronous single-port memory.
  logic [3:0] mem [0:8191];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, hcount, vcount, act, exp);
    end
  endtask

  // Advance one clock and move the raster position on by one pixel.
  task automatic step();
    @(posedge clock);
    #1;
    if (hcount == 10'd793) begin
      hcount = 10'd0;
      vcount = (vcount == 10'd527) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount = hcount + 10'd1;
    end
  endtask

  task automatic set_pos(input logic [9:0] h, input logic [9:0] v);
    @(posedge clock);
    #1;
    hcount = h;
    vcount = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
    check({tag, "_gl_rvalid"},  32'(gl_rvalid),  32'd0);
    check({tag, "_gl_rdata"},   32'(gl_rdata),   32'd0);
    check({tag, "_cell_data"},  32'(cell_data),  32'd0);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        exp_ready;
    logic [12:0] exp_addr;   // display address, meaningful when exp_ready == 0
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic acc1, acc2, exp_tick, reached;
    int   h, v, nl;
    logic exp_slot;

    for (int i = 0; i < 8192; i++) mem[i] <= 4'(i % 16);

    vecs[0]  = '{10'd2,   10'd0,   1'b0, 13'd1};
    vecs[1]  = '{10'd10,  10'd16,  1'b0, 13'd162};
    vecs[2]  = '{10'd626, 10'd479, 1'b0, 13'd4799};
    vecs[3]  = '{10'd634, 10'd16,  1'b1, 13'd0};
    vecs[4]  = '{10'd3,   10'd16,  1'b1, 13'd0};
    vecs[5]  = '{10'd2,   10'd480, 1'b1, 13'd0};
    vecs[6]  = '{10'd788, 10'd15,  1'b0, 13'd160};
    vecs[7]  = '{10'd788, 10'd479, 1'b1, 13'd0};
    vecs[8]  = '{10'd788, 10'd527, 1'b0, 13'd0};
    vecs[9]  = '{10'd788, 10'd500, 1'b1, 13'd0};
    vecs[10] = '{10'd788, 10'd100, 1'b0, 13'd960};
    vecs[11] = '{10'd787, 10'd100, 1'b1, 13'd0};
    vecs[12] = '{10'd789, 10'd100, 1'b1, 13'd0};
    vecs[13] = '{10'd618, 10'd100, 1'b0, 13'd1038};
    vecs[14] = '{10'd0,   10'd0,   1'b1, 13'd0};
    vecs[15] = '{10'd7,   10'd0,   1'b1, 13'd0};

    resetn   = 1'b0;
    hcount   = 10'd0;
    vcount   = 10'd0;
    gl_valid = 1'b0;
    gl_we    = 1'b0;
    gl_addr  = 13'd0;
    gl_wdata = 4'd0;

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Slot decoder and display addresses.
    for (int i = 0; i < 16; i++) begin
      set_pos(vecs[i].h, vecs[i].v);
      gl_valid = 1'b0;
      #1;
      check("vec_ready", 32'(gl_ready), 32'(vecs[i].exp_ready));
      step();
      #1;
      check("vec_mem_we", 32'(mem_we), 32'd0);
      if (!vecs[i].exp_ready) check("vec_mem_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
    end

    // Full display line at vcount 16 (row 2).
    set_pos(10'd786, 10'd15);
    for (int n = 0; n < 800; n++) begin
      #1;
      if (vcount == 10'd16 && hcount < 10'd640 && (hcount[2:0] == 3'd0 || hcount[2:0] == 3'd7))
        check("line_cell", 32'(cell_data), 32'((160 + int'(hcount) / 8) % 16));
      step();
    end

    // Continuous game reads at 0x123 across an active line.
    set_pos(10'd0, 10'd50);
    gl_valid = 1'b1;
    gl_we    = 1'b0;
    gl_addr  = 13'h123;
    acc1 = 1'b0;
    acc2 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      #1;
      h  = int'(hcount);
      v  = int'(vcount);
      nl = (v == 527) ? 0 : v + 1;
      exp_slot = (v < 480 && h % 8 == 2 && h <= 626) || (h == 788 && nl < 480);
      check("hold_ready", 32'(gl_ready), 32'(!exp_slot));
      check("hold_rvalid", 32'(gl_rvalid), 32'(acc2));
      if (acc2) check("hold_rdata", 32'(gl_rdata), 32'h3);
      acc2 = acc1;
      acc1 = !exp_slot;
      step();
    end
    gl_valid = 1'b0;

    // Write then read the same address on consecutive cycles.
    set_pos(10'd100, 10'd50);
    gl_valid = 1'b1; gl_we = 1'b1; gl_addr = 13'd5; gl_wdata = 4'hA;
    #1;
    check("wr_ready", 32'(gl_ready), 32'd1);
    step();
    gl_we = 1'b0;
    #1;
    check("rd_ready", 32'(gl_ready), 32'd1);
    step();
    gl_valid = 1'b0;
    #1;
    check("wr_no_rvalid", 32'(gl_rvalid), 32'd0);
    step();
    #1;
    check("rd_rvalid", 32'(gl_rvalid), 32'd1);
    check("rd_rdata", 32'(gl_rdata), 32'hA);
    step();
    #1;
    check("rd_rvalid_pulse", 32'(gl_rvalid), 32'd0);

    // Game write to row 3 column 0 shows up on line 24.
    set_pos(10'd700, 10'd23);
    gl_valid = 1'b1; gl_we = 1'b1; gl_addr = 13'd240; gl_wdata = 4'h9;
    #1;
    check("row3_ready", 32'(gl_ready), 32'd1);
    step();
    gl_valid = 1'b0; gl_we = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (vcount == 10'd24 && hcount < 10'd8) check("row3_col0", 32'(cell_data), 32'h9);
      if (vcount == 10'd24 && hcount == 10'd8) begin
        check("row3_col1", 32'(cell_data), 32'h1);
        reached = 1'b1;
        break;
      end
      step();
    end
    check("row3_reached", 32'(reached), 32'd1);

    // Reset in the middle of a game read.
    set_pos(10'd300, 10'd20);
    repeat (20) step();
    gl_valid = 1'b1; gl_we = 1'b0; gl_addr = 13'h123;
    #1;
    check("rst_pre_ready", 32'(gl_ready), 32'd1);
    step();
    gl_valid = 1'b0;
    #1;
    check("rst_pre_addr", 32'(mem_addr), 32'h123);
    check("rst_pre_cell", 32'(cell_data), 32'h8);
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    step();
    resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      check("postrst_rvalid", 32'(gl_rvalid), 32'd0);
      step();
    end

    // Vertical blank: no next-line slots until line 527, frame tick timing.
    set_pos(10'd600, 10'd479);
    exp_tick = 1'b0;
    reached  = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      #1;
      check("frame_tick", 32'(frame_tick), 32'(exp_tick));
      if (hcount == 10'd788 && vcount >= 10'd479)
        check("vb_ready_788", 32'(gl_ready), 32'(vcount != 10'd527));
      if (hcount == 10'd789 && vcount == 10'd526)
        check("vb_addr_held", 32'(mem_addr), 32'd4799);
      if (hcount == 10'd789 && vcount == 10'd527) begin
        check("vb_addr_row0", 32'(mem_addr), 32'd0);
        check("vb_we_row0", 32'(mem_we), 32'd0);
      end
      exp_tick = (hcount == 10'd793 && vcount == 10'd479);
      if (hcount == 10'd20 && vcount == 10'd0) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    check("vb_reached", 32'(reached), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
